// File: rtl/trap_pkg.sv
// Shared constants for the machine-mode trap controller: FSM states, cause codes,
// mstatus bit positions and the CSR addresses it writes.
package trap_pkg;

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_W_MEPC    = 3'd1;
    localparam logic [2:0] S_W_MTVAL   = 3'd2;
    localparam logic [2:0] S_W_MSTATUS = 3'd3;
    localparam logic [2:0] S_ASSERT    = 3'd4;

    localparam logic [4:0] CAUSE_ILLEGAL = 5'd2;
    localparam logic [4:0] CAUSE_EBREAK  = 5'd3;
    localparam logic [4:0] CAUSE_ECALL   = 5'd11;
    localparam logic [4:0] IRQ_SOFTWARE  = 5'd3;
    localparam logic [4:0] IRQ_TIMER     = 5'd7;
    localparam logic [4:0] IRQ_EXTERNAL  = 5'd11;
    localparam logic [4:0] FAST_BASE     = 5'd16;

    localparam int MSTATUS_MIE    = 3;
    localparam int MSTATUS_MPIE   = 7;
    localparam int MSTATUS_MPP_LO = 11;
    localparam int MSTATUS_MPP_HI = 12;

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;
    localparam logic [11:0] CSR_MTVAL   = 12'h343;

    function automatic logic [31:0] csr_addr(input logic [11:0] a);
        return {20'd0, a};
    endfunction

endpackage

// File: rtl/trap_irq_arbiter.sv
// Fixed-priority interrupt picker: external > software > timer > fast[0] > ... > fast[N-1].
// Inputs are already masked by mie and the global enable.
module trap_irq_arbiter import trap_pkg::*; #(
    parameter int NUM_FAST_IRQ = 15
) (
    input  logic                    ext_i,
    input  logic                    sw_i,
    input  logic                    timer_i,
    input  logic [NUM_FAST_IRQ-1:0] fast_i,
    output logic                    req_o,
    output logic [4:0]              code_o
);

    always_comb begin
        req_o  = 1'b0;
        code_o = 5'd0;
        // Walk from lowest to highest priority so the last hit wins.
        for (int i = NUM_FAST_IRQ - 1; i >= 0; i--) begin
            if (fast_i[i]) begin
                req_o  = 1'b1;
                code_o = FAST_BASE + 5'(i);
            end
        end
        if (timer_i) begin
            req_o  = 1'b1;
            code_o = IRQ_TIMER;
        end
        if (sw_i) begin
            req_o  = 1'b1;
            code_o = IRQ_SOFTWARE;
        end
        if (ext_i) begin
            req_o  = 1'b1;
            code_o = IRQ_EXTERNAL;
        end
    end

endmodule

// File: rtl/trap_ctrl.sv
// Machine-mode trap controller: takes exceptions, interrupts and mret, sequences the
// CSR writes through the single write port and redirects fetch.
//
// state       | meaning
// S_IDLE      | sample requests, write mcause on a trap
// S_W_MEPC    | write mepc with the trapping instruction address
// S_W_MTVAL   | write mtval (skipped when TVAL_EN = 0)
// S_W_MSTATUS | write mstatus for trap entry or mret
// S_ASSERT    | one-cycle redirect pulse to the latched target
module trap_ctrl import trap_pkg::*; #(
    parameter int NUM_FAST_IRQ = 15,
    parameter bit TVAL_EN      = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    inst_valid_i,
    input  logic [31:0]             inst_addr_i,
    input  logic [31:0]             inst_data_i,
    input  logic                    inst_illegal_i,
    input  logic                    inst_ecall_i,
    input  logic                    inst_ebreak_i,
    input  logic                    inst_mret_i,
    input  logic [31:0]             mtvec_i,
    input  logic [31:0]             mstatus_i,
    input  logic [31:0]             mie_i,
    input  logic [31:0]             mepc_i,
    input  logic                    irq_external_i,
    input  logic                    irq_software_i,
    input  logic                    irq_timer_i,
    input  logic [NUM_FAST_IRQ-1:0] irq_fast_i,
    output logic                    csr_we_o,
    output logic [31:0]             csr_waddr_o,
    output logic [31:0]             csr_wdata_o,
    output logic                    stall_flag_o,
    output logic                    int_assert_o,
    output logic [31:0]             int_addr_o
);

    logic [2:0]              state_q, state_d;
    logic [31:0]             cause_q, cause_d;
    logic [31:0]             target_q, target_d;
    logic [31:0]             addr_q, addr_d;
    logic [31:0]             tval_q, tval_d;

    logic                    irq_en, exc_req, irq_req;
    logic [4:0]              irq_code, exc_code;
    logic [NUM_FAST_IRQ-1:0] fast_masked;
    logic [31:0]             base, trap_target, cause_new;
    logic [31:0]             mstatus_trap, mstatus_mret;
    logic                    unused_mie;

    assign unused_mie = ^mie_i;
    assign irq_en     = inst_valid_i & mstatus_i[MSTATUS_MIE];

    always_comb begin
        for (int i = 0; i < NUM_FAST_IRQ; i++) begin
            fast_masked[i] = irq_fast_i[i] & mie_i[16 + i] & irq_en;
        end
    end

    trap_irq_arbiter #(.NUM_FAST_IRQ(NUM_FAST_IRQ)) u_arb (
        .ext_i   (irq_external_i & mie_i[IRQ_EXTERNAL] & irq_en),
        .sw_i    (irq_software_i & mie_i[IRQ_SOFTWARE] & irq_en),
        .timer_i (irq_timer_i & mie_i[IRQ_TIMER] & irq_en),
        .fast_i  (fast_masked),
        .req_o   (irq_req),
        .code_o  (irq_code)
    );

    assign exc_req  = inst_illegal_i | inst_ecall_i | inst_ebreak_i;
    assign exc_code = inst_illegal_i ? CAUSE_ILLEGAL :
                      inst_ecall_i   ? CAUSE_ECALL   : CAUSE_EBREAK;
    assign cause_new = exc_req ? {27'd0, exc_code} : {1'b1, 26'd0, irq_code};

    assign base        = {mtvec_i[31:2], 2'b00};
    assign trap_target = (!exc_req && mtvec_i[1:0] == 2'b01) ?
                         base + {25'd0, irq_code, 2'b00} : base;

    always_comb begin
        mstatus_trap = mstatus_i;
        mstatus_trap[MSTATUS_MPIE] = mstatus_i[MSTATUS_MIE];
        mstatus_trap[MSTATUS_MIE]  = 1'b0;
        mstatus_trap[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
        mstatus_mret = mstatus_i;
        mstatus_mret[MSTATUS_MIE]  = mstatus_i[MSTATUS_MPIE];
        mstatus_mret[MSTATUS_MPIE] = 1'b1;
        mstatus_mret[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
    end

    always_comb begin
        state_d      = state_q;
        cause_d      = cause_q;
        target_d     = target_q;
        addr_d       = addr_q;
        tval_d       = tval_q;
        csr_we_o     = 1'b0;
        csr_waddr_o  = 32'd0;
        csr_wdata_o  = 32'd0;
        stall_flag_o = 1'b0;
        int_assert_o = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (exc_req || irq_req) begin
                    csr_we_o     = 1'b1;
                    csr_waddr_o  = csr_addr(CSR_MCAUSE);
                    csr_wdata_o  = cause_new;
                    stall_flag_o = 1'b1;
                    cause_d      = cause_new;
                    target_d     = trap_target;
                    addr_d       = inst_addr_i;
                    tval_d       = inst_illegal_i ? inst_data_i : 32'd0;
                    state_d      = S_W_MEPC;
                end else if (inst_mret_i) begin
                    // Cause 0 is never raised here, so it marks an mret in S_W_MSTATUS.
                    stall_flag_o = 1'b1;
                    cause_d      = 32'd0;
                    target_d     = mepc_i;
                    state_d      = S_W_MSTATUS;
                end
            end
            S_W_MEPC: begin
                csr_we_o     = 1'b1;
                csr_waddr_o  = csr_addr(CSR_MEPC);
                csr_wdata_o  = addr_q;
                stall_flag_o = 1'b1;
                state_d      = TVAL_EN ? S_W_MTVAL : S_W_MSTATUS;
            end
            S_W_MTVAL: begin
                csr_we_o     = 1'b1;
                csr_waddr_o  = csr_addr(CSR_MTVAL);
                csr_wdata_o  = tval_q;
                stall_flag_o = 1'b1;
                state_d      = S_W_MSTATUS;
            end
            S_W_MSTATUS: begin
                csr_we_o     = 1'b1;
                csr_waddr_o  = csr_addr(CSR_MSTATUS);
                csr_wdata_o  = (cause_q == 32'd0) ? mstatus_mret : mstatus_trap;
                stall_flag_o = 1'b1;
                state_d      = S_ASSERT;
            end
            S_ASSERT: begin
                int_assert_o = 1'b1;
                state_d      = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign int_addr_o = target_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cause_q  <= 32'd0;
            target_q <= 32'd0;
            addr_q   <= 32'd0;
            tval_q   <= 32'd0;
        end else begin
            state_q  <= state_d;
            cause_q  <= cause_d;
            target_q <= target_d;
            addr_q   <= addr_d;
            tval_q   <= tval_d;
        end
    end

endmodule

// File: tb/tb_trap_ctrl.sv
// Bench for trap_ctrl: two instances (with and without mtval write) driven by shared
// inputs, a per-cycle trace model, directed literal cases and a random phase.
module tb_trap_ctrl;

    localparam int N = 15;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          inst_valid_i;
    logic [31:0]   inst_addr_i, inst_data_i;
    logic          ill, ecall, ebreak, mret;
    logic [31:0]   mtvec_i, mstatus_i, mie_i, mepc_i;
    logic          irq_ext, irq_sw, irq_tmr;
    logic [N-1:0]  irq_fast;

    logic          we0, we1, st0, st1, as0, as1;
    logic [31:0]   wa0, wa1, wd0, wd1, ia0, ia1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    trap_ctrl #(.NUM_FAST_IRQ(N), .TVAL_EN(1'b1)) dut0 (
        .clk(clk), .rst_n(rst_n), .inst_valid_i(inst_valid_i), .inst_addr_i(inst_addr_i),
        .inst_data_i(inst_data_i), .inst_illegal_i(ill), .inst_ecall_i(ecall),
        .inst_ebreak_i(ebreak), .inst_mret_i(mret), .mtvec_i(mtvec_i), .mstatus_i(mstatus_i),
        .mie_i(mie_i), .mepc_i(mepc_i), .irq_external_i(irq_ext), .irq_software_i(irq_sw),
        .irq_timer_i(irq_tmr), .irq_fast_i(irq_fast), .csr_we_o(we0), .csr_waddr_o(wa0),
        .csr_wdata_o(wd0), .stall_flag_o(st0), .int_assert_o(as0), .int_addr_o(ia0)
    );

    trap_ctrl #(.NUM_FAST_IRQ(N), .TVAL_EN(1'b0)) dut1 (
        .clk(clk), .rst_n(rst_n), .inst_valid_i(inst_valid_i), .inst_addr_i(inst_addr_i),
        .inst_data_i(inst_data_i), .inst_illegal_i(ill), .inst_ecall_i(ecall),
        .inst_ebreak_i(ebreak), .inst_mret_i(mret), .mtvec_i(mtvec_i), .mstatus_i(mstatus_i),
        .mie_i(mie_i), .mepc_i(mepc_i), .irq_external_i(irq_ext), .irq_software_i(irq_sw),
        .irq_timer_i(irq_tmr), .irq_fast_i(irq_fast), .csr_we_o(we1), .csr_waddr_o(wa1),
        .csr_wdata_o(wd1), .stall_flag_o(st1), .int_assert_o(as1), .int_addr_o(ia1)
    );

    typedef struct packed {
        logic        we;
        logic [31:0] wa;
        logic [31:0] wd;
        logic        st;
        logic        as;
        logic [31:0] ia;
    } exp_t;

    exp_t        q0[$], q1[$];
    logic [31:0] tgt0 = 32'd0, tgt1 = 32'd0;
    exp_t        r0[6], r1[6];

    function automatic exp_t mk(logic we, logic [31:0] wa, logic [31:0] wd,
                                logic st, logic as, logic [31:0] ia);
        exp_t e;
        e.we = we; e.wa = wa; e.wd = wd; e.st = st; e.as = as; e.ia = ia;
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Expected output trace of a whole request, derived from the current inputs.
    task automatic predict(input bit tval_en, input logic [31:0] old_tgt,
                           output exp_t seq[6], output int n, output logic [31:0] new_tgt);
        logic [31:0] base, m, cause, tval, t;
        int code;
        n = 0;
        new_tgt = old_tgt;
        base = mtvec_i & 32'hFFFF_FFFC;
        m = mstatus_i;
        code = -1;
        t = base;
        cause = 32'd0;
        tval = 32'd0;
        for (int k = 0; k < 6; k++) seq[k] = mk(0, 0, 0, 0, 0, 0);
        if (inst_valid_i && m[3]) begin
            if (irq_ext && mie_i[11]) code = 11;
            else if (irq_sw && mie_i[3]) code = 3;
            else if (irq_tmr && mie_i[7]) code = 7;
            else begin
                for (int i = 0; i < N; i++)
                    if (code < 0 && irq_fast[i] && mie_i[16 + i]) code = 16 + i;
            end
        end
        if (ill || ecall || ebreak || code >= 0) begin
            if (ill || ecall || ebreak) begin
                cause = ill ? 32'd2 : (ecall ? 32'd11 : 32'd3);
                tval  = ill ? inst_data_i : 32'd0;
            end else begin
                cause = 32'h8000_0000 + 32'(code);
                if (mtvec_i[1:0] == 2'b01) t = base + 32'(4 * code);
            end
            seq[n] = mk(1, 32'h342, cause, 1, 0, old_tgt); n++;
            seq[n] = mk(1, 32'h341, inst_addr_i, 1, 0, t); n++;
            if (tval_en) begin seq[n] = mk(1, 32'h343, tval, 1, 0, t); n++; end
            seq[n] = mk(1, 32'h300, (m & ~32'h1888) | 32'h1800 | (m[3] ? 32'h80 : 32'h0), 1, 0, t); n++;
            seq[n] = mk(0, 0, 0, 0, 1, t); n++;
            new_tgt = t;
        end else if (mret) begin
            seq[n] = mk(0, 0, 0, 1, 0, old_tgt); n++;
            seq[n] = mk(1, 32'h300, (m & ~32'h1888) | 32'h1880 | (m[7] ? 32'h8 : 32'h0), 1, 0, mepc_i); n++;
            seq[n] = mk(0, 0, 0, 0, 1, mepc_i); n++;
            new_tgt = mepc_i;
        end
    endtask

    task automatic cmp(input string tag, input exp_t e, input exp_t a);
        chk({tag, " csr_we"}, 32'(a.we), 32'(e.we));
        if (e.we) begin
            chk({tag, " csr_waddr"}, a.wa, e.wa);
            chk({tag, " csr_wdata"}, a.wd, e.wd);
        end
        chk({tag, " stall"}, 32'(a.st), 32'(e.st));
        chk({tag, " int_assert"}, 32'(a.as), 32'(e.as));
        chk({tag, " int_addr"}, a.ia, e.ia);
    endtask

    always @(negedge clk) begin
        exp_t        e0, e1;
        exp_t        s[6];
        int          n;
        logic [31:0] nt;
        if (!rst_n) begin
            q0.delete(); q1.delete();
            tgt0 = 32'd0; tgt1 = 32'd0;
            e0 = mk(0, 0, 0, 0, 0, 0);
            e1 = e0;
        end else begin
            if (q0.size() == 0) begin
                predict(1'b1, tgt0, s, n, nt);
                for (int k = 0; k < n; k++) q0.push_back(s[k]);
                tgt0 = nt;
            end
            if (q0.size() == 0) q0.push_back(mk(0, 0, 0, 0, 0, tgt0));
            if (q1.size() == 0) begin
                predict(1'b0, tgt1, s, n, nt);
                for (int k = 0; k < n; k++) q1.push_back(s[k]);
                tgt1 = nt;
            end
            if (q1.size() == 0) q1.push_back(mk(0, 0, 0, 0, 0, tgt1));
            e0 = q0.pop_front();
            e1 = q1.pop_front();
        end
        cmp("model dut0", e0, mk(we0, wa0, wd0, st0, as0, ia0));
        cmp("model dut1", e1, mk(we1, wa1, wd1, st1, as1, ia1));
    end

    task automatic clear_req();
        ill = 0; ecall = 0; ebreak = 0; mret = 0;
        irq_ext = 0; irq_sw = 0; irq_tmr = 0; irq_fast = '0; inst_valid_i = 0;
    endtask

    task automatic clear_all();
        clear_req();
        inst_addr_i = 0; inst_data_i = 0; mtvec_i = 0; mstatus_i = 0; mie_i = 0; mepc_i = 0;
    endtask

    task automatic start();
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic capture(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            r0[k] = mk(we0, wa0, wd0, st0, as0, ia0);
            r1[k] = mk(we1, wa1, wd1, st1, as1, ia1);
            if (k == 0) begin
                @(posedge clk);
                #1 clear_req();
            end
        end
    endtask

    initial begin
        logic [31:0] r;
        bit busy;
        clear_all();
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("reset int_addr", ia0, 32'h0);
        chk("reset csr_we", 32'(we0), 32'h0);
        chk("reset stall", 32'(st0), 32'h0);
        chk("reset int_assert", 32'(as0), 32'h0);

        start();
        mtvec_i = 32'h1001; mstatus_i = 32'h8; inst_addr_i = 32'h100; ecall = 1;
        capture(6);
        chk("ecall mcause addr", r0[0].wa, 32'h342);
        chk("ecall mcause", r0[0].wd, 32'hB);
        chk("ecall stall T0", 32'(r0[0].st), 32'h1);
        chk("ecall mepc", r0[1].wd, 32'h100);
        chk("ecall mtval addr", r0[2].wa, 32'h343);
        chk("ecall mtval", r0[2].wd, 32'h0);
        chk("ecall mstatus", r0[3].wd, 32'h1880);
        chk("ecall assert T4", 32'(r0[4].as), 32'h1);
        chk("ecall stall T4", 32'(r0[4].st), 32'h0);
        chk("ecall target", r0[4].ia, 32'h1000);
        chk("notval T2 waddr", r1[2].wa, 32'h300);
        chk("notval assert T3", 32'(r1[3].as), 32'h1);
        chk("notval target", r1[3].ia, 32'h1000);

        start();
        inst_valid_i = 1; mstatus_i = 32'h8; mie_i = 32'h80; irq_tmr = 1;
        capture(6);
        chk("timer mcause", r0[0].wd, 32'h8000_0007);
        chk("timer target", r0[4].ia, 32'h101C);

        start();
        inst_valid_i = 1; mstatus_i = 32'h0; mie_i = 32'h80; irq_tmr = 1;
        capture(2);
        chk("timer mie0 stall", 32'(r0[0].st), 32'h0);
        chk("timer mie0 we", 32'(r0[0].we), 32'h0);

        start();
        inst_valid_i = 1; mstatus_i = 32'h8; mie_i = 32'h800; irq_ext = 1;
        ill = 1; inst_data_i = 32'hFFFF_FFFF;
        capture(6);
        chk("illegal mcause", r0[0].wd, 32'h2);
        chk("illegal mtval", r0[2].wd, 32'hFFFF_FFFF);
        chk("illegal target", r0[4].ia, 32'h1000);

        start();
        inst_valid_i = 1; mie_i = 32'h0008_0000; irq_fast = N'(15'h0028);
        capture(6);
        chk("fast mcause", r0[0].wd, 32'h8000_0013);
        chk("fast target", r0[4].ia, 32'h104C);

        start();
        inst_valid_i = 1; mie_i = 32'h0; irq_fast = N'(15'h0028);
        capture(2);
        chk("fast masked stall", 32'(r0[0].st), 32'h0);

        start();
        mstatus_i = 32'h1880; mepc_i = 32'h200; mret = 1;
        capture(4);
        chk("mret T0 we", 32'(r0[0].we), 32'h0);
        chk("mret T0 stall", 32'(r0[0].st), 32'h1);
        chk("mret mstatus addr", r0[1].wa, 32'h300);
        chk("mret mstatus", r0[1].wd, 32'h1888);
        chk("mret assert T2", 32'(r0[2].as), 32'h1);
        chk("mret target", r0[2].ia, 32'h200);

        start();
        mstatus_i = 32'h8; ecall = 1; inst_addr_i = 32'h300;
        @(negedge clk);
        chk("rst test T0 we", 32'(we0), 32'h1);
        @(posedge clk);
        #1 rst_n = 1'b0;
        clear_all();
        @(negedge clk);
        chk("rst during we", 32'(we0), 32'h0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk("rst after we0", 32'(we0), 32'h0);
            chk("rst after we1", 32'(we1), 32'h0);
            chk("rst after assert0", 32'(as0), 32'h0);
            chk("rst after assert1", 32'(as1), 32'h0);
            chk("rst after int_addr", ia0, 32'h0);
        end

        for (int c = 0; c < 3000; c++) begin
            @(posedge clk);
            #1;
            busy = (q0.size() != 0) || (q1.size() != 0);
            inst_valid_i = ($urandom_range(0, 3) != 0);
            inst_addr_i  = $urandom;
            inst_data_i  = $urandom;
            ill    = ($urandom_range(0, 15) == 0);
            ecall  = ($urandom_range(0, 15) == 0);
            ebreak = ($urandom_range(0, 15) == 0);
            mret   = ($urandom_range(0, 7) == 0);
            irq_ext = ($urandom_range(0, 5) == 0);
            irq_sw  = ($urandom_range(0, 5) == 0);
            irq_tmr = ($urandom_range(0, 5) == 0);
            r = $urandom & $urandom & $urandom;
            irq_fast = r[N-1:0];
            mie_i  = $urandom;
            mepc_i = $urandom;
            r = $urandom;
            mtvec_i = {r[31:2], ($urandom_range(0, 1) != 0) ? 2'b01 : 2'($urandom_range(0, 3))};
            if (!busy) mstatus_i = $urandom;
        end
        @(posedge clk);
        #1 clear_req();
        repeat (8) @(posedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
